// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: pushbutton, counter-pair and display signals of the stopwatch controller.
// The controller connects through the slave modport; the button/counter side uses master.
interface stopwatch_ctrl_if;
    logic       pb_start;
    logic       pb_rst_debounced;
    logic       pb_lap;
    logic       pb_inc;
    logic       mode_enable;
    logic [3:0] cnt_digit1;
    logic [3:0] cnt_digit0;
    logic       carry_min;
    logic       count_en;
    logic       counter_rst;
    logic [3:0] init_1;
    logic [3:0] init_0;
    logic [3:0] minutes;
    logic [3:0] disp_digit1;
    logic [3:0] disp_digit0;
    logic [1:0] state;

    modport master (
        output pb_start, pb_rst_debounced, pb_lap, pb_inc, mode_enable,
        output cnt_digit1, cnt_digit0, carry_min,
        input  count_en, counter_rst, init_1, init_0, minutes,
        input  disp_digit1, disp_digit0, state
    );

    modport slave (
        input  pb_start, pb_rst_debounced, pb_lap, pb_inc, mode_enable,
        input  cnt_digit1, cnt_digit0, carry_min,
        output count_en, counter_rst, init_1, init_0, minutes,
        output disp_digit1, disp_digit0, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM for the Lab6 BCD seconds counter (tick, load, minutes, display).
// Build option: define LAP_EN to include the lap-freeze registers and display path.
module stopwatch_ctrl #(
    parameter int TICK_CNT = 100000000,
    parameter int PRESC_W  = 27
) (
    input  logic           clk,
    input  logic           rst_n,
    stopwatch_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_SET   = 2'b11;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CNT - 1);

    logic [1:0]         r_state;
    logic [PRESC_W-1:0] r_presc;
    logic               r_counter_rst;
    logic [3:0]         r_init_1;
    logic [3:0]         r_init_0;
    logic [3:0]         r_minutes;
    logic               w_tick;
    logic [3:0]         w_disp1;
    logic [3:0]         w_disp0;

    function automatic logic [7:0] bcd_sec_inc(input logic [3:0] tens, input logic [3:0] units);
        if (units >= 4'd9) begin
            if (tens >= 4'd5) return 8'h00;
            return {tens + 4'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

    function automatic logic [3:0] bcd_min_inc(input logic [3:0] m);
        return (m >= 4'd9) ? 4'd0 : m + 4'd1;
    endfunction

    assign w_tick = (r_state == S_RUN) && (r_presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_presc       <= '0;
            r_counter_rst <= 1'b0;
            r_init_1      <= 4'd0;
            r_init_0      <= 4'd0;
            r_minutes     <= 4'd0;
        end else begin
            r_counter_rst <= 1'b0;
            if (w_tick && bus.carry_min)
                r_minutes <= bcd_min_inc(r_minutes);
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    if (bus.pb_rst_debounced) begin
                        r_counter_rst <= 1'b1;
                        r_minutes     <= 4'd0;
                    end else if (bus.pb_start) begin
                        r_state <= S_RUN;
                    end else if (bus.mode_enable) begin
                        r_state <= S_SET;
                    end
                end
                S_RUN: begin
                    if (bus.pb_rst_debounced) begin
                        r_state       <= S_IDLE;
                        r_counter_rst <= 1'b1;
                        r_presc       <= '0;
                        r_minutes     <= 4'd0;
                    end else if (bus.pb_start) begin
                        // A tick issued while pausing completes the period, so restart from 0.
                        r_state <= S_PAUSE;
                        r_presc <= w_tick ? '0 : r_presc;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (bus.pb_rst_debounced) begin
                        r_state       <= S_IDLE;
                        r_counter_rst <= 1'b1;
                        r_presc       <= '0;
                        r_minutes     <= 4'd0;
                    end else if (bus.pb_start) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    if (bus.pb_rst_debounced) begin
                        r_init_1 <= 4'd0;
                        r_init_0 <= 4'd0;
                    end else if (!bus.mode_enable) begin
                        r_state       <= S_IDLE;
                        r_counter_rst <= 1'b1;
                    end else if (bus.pb_inc) begin
                        {r_init_1, r_init_0} <= bcd_sec_inc(r_init_1, r_init_0);
                    end
                end
            endcase
        end
    end

`ifdef LAP_EN
    logic       r_lap_hold;
    logic [3:0] r_lap_1;
    logic [3:0] r_lap_0;
    logic       w_lap_press;

    // pb_lap only acts when no higher-priority button is pressed in the same cycle.
    assign w_lap_press = bus.pb_lap && !bus.pb_rst_debounced && !bus.pb_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_hold <= 1'b0;
            r_lap_1    <= 4'd0;
            r_lap_0    <= 4'd0;
        end else if (bus.pb_rst_debounced && (r_state != S_SET)) begin
            r_lap_hold <= 1'b0;
        end else if (w_lap_press && (r_state == S_RUN) && !r_lap_hold) begin
            r_lap_hold <= 1'b1;
            r_lap_1    <= bus.cnt_digit1;
            r_lap_0    <= bus.cnt_digit0;
        end else if (w_lap_press && r_lap_hold &&
                     ((r_state == S_RUN) || (r_state == S_PAUSE))) begin
            r_lap_hold <= 1'b0;
        end
    end

    always_comb begin
        w_disp1 = bus.cnt_digit1;
        w_disp0 = bus.cnt_digit0;
        if (r_lap_hold) begin
            w_disp1 = r_lap_1;
            w_disp0 = r_lap_0;
        end else if (r_state == S_SET) begin
            w_disp1 = r_init_1;
            w_disp0 = r_init_0;
        end
    end
`else
    logic w_unused_lap;
    assign w_unused_lap = bus.pb_lap;

    always_comb begin
        w_disp1 = bus.cnt_digit1;
        w_disp0 = bus.cnt_digit0;
        if (r_state == S_SET) begin
            w_disp1 = r_init_1;
            w_disp0 = r_init_0;
        end
    end
`endif

    assign bus.count_en    = w_tick;
    assign bus.counter_rst = r_counter_rst;
    assign bus.init_1      = r_init_1;
    assign bus.init_0      = r_init_0;
    assign bus.minutes     = r_minutes;
    assign bus.disp_digit1 = w_disp1;
    assign bus.disp_digit0 = w_disp0;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven and sequence checks of stopwatch_ctrl with TICK_CNT=4.
// Lap expectations follow the LAP_EN build option.
module tb_stopwatch_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

`ifdef LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.TICK_CNT(4), .PRESC_W(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, rst, lap, inc, mode, carry;
        logic [1:0] e_state;
        logic       e_ce, e_crst;
        logic [3:0] e_min, e_d1, e_d0;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic s, r, l, i, m, c,
                               input logic [1:0] st, input logic ce, crst,
                               input logic [3:0] mn, d1, d0);
        vec_t x;
        x.start = s; x.rst = r; x.lap = l; x.inc = i; x.mode = m; x.carry = c;
        x.e_state = st; x.e_ce = ce; x.e_crst = crst;
        x.e_min = mn; x.e_d1 = d1; x.e_d0 = d0;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sw_if.pb_start = 1'b0;
        sw_if.pb_rst_debounced = 1'b0;
        sw_if.pb_lap = 1'b0;
        sw_if.pb_inc = 1'b0;
        sw_if.mode_enable = 1'b0;
        sw_if.carry_min = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        sw_if.pb_start = 1'b1;
        tick();
        sw_if.pb_start = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        int crst_cnt;
        bit found;
        bit left_pause;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        clear_inputs();
        sw_if.cnt_digit1 = 4'd1;
        sw_if.cnt_digit0 = 4'd2;

        // Reset state while rst_n is held low across clock edges.
        tick();
        tick();
        chk("rst_state", int'(sw_if.state), 0);
        chk("rst_count_en", int'(sw_if.count_en), 0);
        chk("rst_counter_rst", int'(sw_if.counter_rst), 0);
        chk("rst_minutes", int'(sw_if.minutes), 0);
        chk("rst_init", int'({sw_if.init_1, sw_if.init_0}), 0);
        chk("rst_disp", int'({sw_if.disp_digit1, sw_if.disp_digit0}), 8'h12);
        rst_n = 1'b1;
        tick();

        //         start rst lap inc mode carry  state ce crst min d1 d0
        vecs.push_back(v(0,0,0,0,0,0, 2'd0,0,0,0,1,2));
        vecs.push_back(v(1,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,1,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,1,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,1,0,0,1,2));
        vecs.push_back(v(0,0,0,0,0,1, 2'd1,0,0,1,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,1,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,1,1,2));
        vecs.push_back(v(1,0,0,0,0,0, 2'd2,0,0,1,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd2,0,0,1,1,2));
        vecs.push_back(v(1,0,0,0,0,0, 2'd1,0,0,1,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,1,0,1,1,2));
        vecs.push_back(v(1,0,0,0,0,0, 2'd2,0,0,1,1,2));
        vecs.push_back(v(1,0,0,0,0,0, 2'd1,0,0,1,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd1,0,0,1,1,2));
        vecs.push_back(v(1,1,0,0,0,0, 2'd0,0,1,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd0,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,1,0, 2'd3,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,1,0, 2'd3,0,0,0,0,1));
        vecs.push_back(v(1,0,0,0,1,0, 2'd3,0,0,0,0,1));
        vecs.push_back(v(0,0,1,0,1,0, 2'd3,0,0,0,0,1));
        vecs.push_back(v(0,1,0,0,1,0, 2'd3,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,1,0, 2'd3,0,0,0,0,1));
        vecs.push_back(v(0,0,0,0,0,0, 2'd0,0,1,0,1,2));
        vecs.push_back(v(0,0,0,0,0,0, 2'd0,0,0,0,1,2));
        vecs.push_back(v(1,0,0,0,0,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,0,0,0,1,0, 2'd1,0,0,0,1,2));
        vecs.push_back(v(0,1,0,0,1,0, 2'd0,0,1,0,1,2));

        foreach (vecs[i]) begin
            sw_if.pb_start = vecs[i].start;
            sw_if.pb_rst_debounced = vecs[i].rst;
            sw_if.pb_lap = vecs[i].lap;
            sw_if.pb_inc = vecs[i].inc;
            sw_if.mode_enable = vecs[i].mode;
            sw_if.carry_min = vecs[i].carry;
            tick();
            chk($sformatf("vec%0d_state", i), int'(sw_if.state), int'(vecs[i].e_state));
            chk($sformatf("vec%0d_count_en", i), int'(sw_if.count_en), int'(vecs[i].e_ce));
            chk($sformatf("vec%0d_counter_rst", i), int'(sw_if.counter_rst), int'(vecs[i].e_crst));
            chk($sformatf("vec%0d_minutes", i), int'(sw_if.minutes), int'(vecs[i].e_min));
            chk($sformatf("vec%0d_disp", i), int'({sw_if.disp_digit1, sw_if.disp_digit0}),
                int'({vecs[i].e_d1, vecs[i].e_d0}));
        end
        clear_inputs();

        // Pause at presc=2 holds for 20 cycles, then resumes two cycles from the tick.
        do_reset();
        pulse_start();
        tick();
        tick();
        pulse_start();
        pulses = 0;
        left_pause = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sw_if.count_en) pulses++;
            if (sw_if.state != 2'b10) left_pause = 1'b1;
        end
        chk("pause_no_tick", pulses, 0);
        chk("pause_held", int'(left_pause), 0);
        pulse_start();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (sw_if.count_en) begin
                lat = k;
                break;
            end
            tick();
        end
        chk("resume_latency", lat, 2);

        // Minutes accumulate on every tick with carry and wrap 9 -> 0.
        do_reset();
        sw_if.cnt_digit1 = 4'd5;
        sw_if.cnt_digit0 = 4'd9;
        sw_if.carry_min = 1'b1;
        pulse_start();
        for (int t = 1; t <= 10; t++) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (sw_if.count_en) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            if (!found) chk($sformatf("tick%0d_timeout", t), 0, 1);
            tick();
            chk($sformatf("min_after_%0d", t), int'(sw_if.minutes), t % 10);
        end
        sw_if.carry_min = 1'b0;

        // SET mode: 61 increments land on 01 via the 59 -> 00 wrap, then load on exit.
        do_reset();
        sw_if.cnt_digit1 = 4'd3;
        sw_if.cnt_digit0 = 4'd4;
        sw_if.mode_enable = 1'b1;
        tick();
        chk("set_entry", int'(sw_if.state), 3);
        for (int i = 0; i < 61; i++) begin
            sw_if.pb_inc = 1'b1;
            tick();
            sw_if.pb_inc = 1'b0;
            tick();
            if (i == 59) chk("set_wrap_00", int'({sw_if.init_1, sw_if.init_0}), 0);
            if (i == 58) chk("set_59", int'({sw_if.init_1, sw_if.init_0}), 8'h59);
        end
        chk("set_init_01", int'({sw_if.init_1, sw_if.init_0}), 8'h01);
        chk("set_disp_01", int'({sw_if.disp_digit1, sw_if.disp_digit0}), 8'h01);
        sw_if.mode_enable = 1'b0;
        crst_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (sw_if.counter_rst) begin
                crst_cnt++;
                sw_if.cnt_digit1 = 4'd0;
                sw_if.cnt_digit0 = 4'd1;
            end
        end
        chk("set_exit_crst_pulses", crst_cnt, 1);
        chk("set_exit_state", int'(sw_if.state), 0);
        chk("set_exit_disp", int'({sw_if.disp_digit1, sw_if.disp_digit0}), 8'h01);

        // Lap freeze at 23 while the counter moves on to 27.
        do_reset();
        sw_if.cnt_digit1 = 4'd2;
        sw_if.cnt_digit0 = 4'd3;
        pulse_start();
        tick();
        sw_if.pb_lap = 1'b1;
        tick();
        sw_if.pb_lap = 1'b0;
        chk("lap_capture", int'({sw_if.disp_digit1, sw_if.disp_digit0}), 8'h23);
        sw_if.cnt_digit0 = 4'd7;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sw_if.count_en) pulses++;
        end
        chk("lap_frozen_disp", int'({sw_if.disp_digit1, sw_if.disp_digit0}), LAP ? 8'h23 : 8'h27);
        chk("lap_still_running", int'(sw_if.state), 1);
        chk("lap_ticks_continue", int'(pulses > 0), 1);
        sw_if.pb_lap = 1'b1;
        tick();
        sw_if.pb_lap = 1'b0;
        chk("lap_release", int'({sw_if.disp_digit1, sw_if.disp_digit0}), 8'h27);

        // Asynchronous reset mid-RUN takes effect before the next clock edge.
        do_reset();
        sw_if.carry_min = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) tick();
        sw_if.carry_min = 1'b0;
        chk("pre_async_minutes", int'(sw_if.minutes), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", int'(sw_if.state), 0);
        chk("async_minutes", int'(sw_if.minutes), 0);
        chk("async_count_en", int'(sw_if.count_en), 0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the two-digit BCD seconds counter (00-59, carry to minutes) used in the Lab6 stopwatch. Sits between the debounced/one-pulsed pushbuttons and the counter pair. Generates the counter's count-enable tick, reset/load pulse and initial values, accumulates minutes from the counter carry, and drives the 7-seg display source, including a lap freeze.

Parameters:
TICK_CNT, 100000000, clk cycles per count tick (1 Hz at 100 MHz); must be >= 2
PRESC_W, 27, prescaler width; must satisfy 2^PRESC_W >= TICK_CNT

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
pb_start  in  1  start/pause, debounced one-cycle pulse
pb_rst_debounced  in  1  stopwatch reset, debounced one-cycle pulse
pb_lap  in  1  lap toggle, debounced one-cycle pulse
pb_inc  in  1  SET-mode increment, debounced one-cycle pulse
mode_enable  in  1  level; 1 requests SET mode
cnt_digit1  in  4  live counter tens digit (0-5)
cnt_digit0  in  4  live counter units digit (0-9)
carry_min  in  1  counter carry, high while counter = 59 and an increment is applied
count_en  out  1  one-cycle increment pulse to counter
counter_rst  out  1  one-cycle pulse; counter loads init_1/init_0
init_1  out  4  initial tens digit, BCD 0-5
init_0  out  4  initial units digit, BCD 0-9
minutes  out  4  BCD minutes, 0-9
disp_digit1  out  4  displayed tens digit
disp_digit0  out  4  displayed units digit
state  out  2  IDLE=00, RUN=01, PAUSE=10, SET=11

Behaviour:
- Reset (rst_n=0, async): state=IDLE, presc=0, count_en=0, counter_rst=0, init_1=init_0=0, minutes=0, lap_hold=0, lap regs=0; disp = live counter.
- Button priority within a cycle: pb_rst_debounced > pb_start > pb_lap > pb_inc. Only the highest-priority pulse acts.
- IDLE: pb_start -> RUN. mode_enable=1 (and no pb_start) -> SET. Prescaler held at 0.
- RUN: presc counts 0..TICK_CNT-1 and wraps. count_en = (state==RUN && presc==TICK_CNT-1), decoded combinationally from registers; first pulse exactly TICK_CNT cycles after entering RUN from IDLE. pb_start -> PAUSE.
- PAUSE: presc frozen, keeping the partial tick. pb_start -> RUN and resumes from the held presc value. count_en=0.
- pb_rst_debounced in IDLE/RUN/PAUSE: next state IDLE, counter_rst=1 for exactly one cycle (registered, the cycle after the pulse), presc=0, minutes=0, lap_hold=0.
- SET: pb_inc advances {init_1,init_0} as BCD seconds: x9 -> (x+1)0, 59 -> 00. mode_enable falling (level 0 seen in SET) -> IDLE with one counter_rst pulse so the counter loads the new values. pb_start and pb_lap are ignored in SET. pb_rst_debounced in SET clears init to 00, stays in SET, and issues no counter_rst.
- mode_enable is ignored in RUN and PAUSE.
- Minutes: on any cycle with count_en=1 and carry_min=1, minutes increments BCD 9 -> 0 (wrap, no further carry).
- Lap: in RUN, pb_lap with lap_hold=0 captures cnt_digit1/0 into lap regs and sets lap_hold. pb_lap with lap_hold=1 clears it in RUN or PAUSE. Counting continues underneath.
- Display: lap_hold=1 -> lap regs. state=SET -> init_1/init_0. Otherwise live counter digits.
- A count_en tick coincident with pb_start (pausing): the tick is still issued in that cycle.

Optional Feature:
LAP_EN defined: lap regs, lap_hold and the lap display path are present as described. Undefined: pb_lap is ignored, no lap registers are synthesized, and the display shows the live counter or SET values only.

Test Plan:
- TICK_CNT=4. Reset, then pb_start -> state=01. count_en pulses on cycles 4, 8 and 12 after entry. No counter_rst.
- Run to counter=59 with carry_min=1 on the tick -> minutes 0->1. At minutes=9, another wrap -> minutes=0.
- RUN with presc=2, pb_start -> PAUSE, presc stays 2 for 20 cycles. pb_start -> first count_en 2 cycles after resume.
- mode_enable=1 from IDLE -> SET. Apply 61 pb_inc pulses -> init=01 (via 59->00). Drop mode_enable -> IDLE, single counter_rst pulse, disp=01.
- RUN at counter=23, pb_lap -> disp frozen at 23 while counter advances to 27. pb_lap -> disp live=27.
- pb_rst_debounced and pb_start in the same cycle during RUN -> IDLE, one counter_rst pulse, minutes=0, no PAUSE. Assert rst_n low mid-RUN -> immediate reset values.
